// File: rtl/mod_unit_32bit_if.sv
// Operand/result bundle for the 32-bit modulo unit.
// Handshake: master raises start for one edge with operands valid; the unit accepts only when
// busy is low, then pulses done for exactly one cycle once result/div_by_zero are final.
interface mod_unit_32bit_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  modport master (
    output start, dividend, divisor,
    input  result, busy, done, div_by_zero, state_dbg
  );

  modport slave (
    input  start, dividend, divisor,
    output result, busy, done, div_by_zero, state_dbg
  );
endinterface

// File: rtl/mod_unit_32bit.sv
// Unsigned 32-bit A mod B, restoring shift-subtract, one quotient bit per clock.
// A zero divisor returns the dividend with div_by_zero set and skips the iterations.
module mod_unit_32bit (
  input  logic                    clk,
  input  logic                    reset,
  mod_unit_32bit_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] d_reg_q, d_reg_d;
  logic [31:0] q_reg_q, q_reg_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;

  logic [32:0] rem_shift;
  logic [32:0] rem_sub;

  // 33-bit compare keeps divisors >= 2^31 correct after the shift.
  always_comb begin
    rem_shift = {rem_q[31:0], q_reg_q[31]};
    if (rem_shift >= {1'b0, d_reg_q}) begin
      rem_sub = rem_shift - {1'b0, d_reg_q};
    end else begin
      rem_sub = rem_shift;
    end
  end

  always_comb begin
    state_d  = state_q;
    d_reg_d  = d_reg_q;
    q_reg_d  = q_reg_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_reg_d = bus.divisor;
          q_reg_d = bus.dividend;
          rem_d   = 33'd0;
          cnt_d   = 5'd0;
          if (bus.divisor == 32'd0) begin
            result_d = bus.dividend;
            dbz_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d   = rem_sub;
        q_reg_d = {q_reg_q[30:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = rem_sub[31:0];
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      d_reg_q  <= 32'd0;
      q_reg_q  <= 32'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_reg_q  <= d_reg_d;
      q_reg_q  <= q_reg_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mod_unit_32bit.sv
// Bench for mod_unit_32bit: cycle-level behavioural model plus directed literal checks
// and a long randomized phase with overlapping start pulses.
module tb_mod_unit_32bit;

  logic clk;
  logic reset;
  mod_unit_32bit_if tif ();

  mod_unit_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks edges since acceptance; outputs follow the documented timeline.
  logic        m_busy, m_done, m_dbz, m_zero;
  logic [31:0] m_result, m_pend;
  int          m_t;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_result = 32'd0;
      m_t = 0; m_zero = 1'b0;
    end else if (m_busy) begin
      m_t++;
      m_done = 1'b0;
      if (m_zero) begin
        if (m_t == 1) m_busy = 1'b0;
      end else if (m_t == 32) begin
        m_done = 1'b1;
        m_result = m_pend;
      end else if (m_t == 33) begin
        m_busy = 1'b0;
      end
    end else if (tif.start) begin
      m_busy = 1'b1;
      m_t = 0;
      if (tif.divisor == 32'd0) begin
        m_zero = 1'b1; m_result = tif.dividend; m_dbz = 1'b1; m_done = 1'b1;
        exp_q.push_back(tif.dividend);
      end else begin
        m_zero = 1'b0; m_dbz = 1'b0; m_done = 1'b0;
        m_pend = tif.dividend % tif.divisor;
        exp_q.push_back(m_pend);
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("busy",   {31'd0, tif.busy},        {31'd0, m_busy});
      check("done",   {31'd0, tif.done},        {31'd0, m_done});
      check("result", tif.result,               m_result);
      check("dbz",    {31'd0, tif.div_by_zero}, {31'd0, m_dbz});
      if (tif.done) begin
        if (exp_q.size() == 0) begin
          check("done_without_op", 32'd1, 32'd0);
        end else begin
          check("sb_result", tif.result, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    tif.start = 1'b1; tif.dividend = a; tif.divisor = b;
    @(posedge clk);
    #1;
    tif.start = 1'b0;
    tif.dividend = $urandom; tif.divisor = $urandom;
    lat = 0;
    while (!tif.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_z, input int exp_lat);
    int lat;
    run_op(a, b, lat);
    check({name, "_lat"},    lat, exp_lat);
    check({name, "_result"}, tif.result, exp_r);
    check({name, "_dbz"},    {31'd0, tif.div_by_zero}, {31'd0, exp_z});
    check({name, "_model"},  m_result, exp_r);
    @(posedge clk);
    #1;
    check({name, "_done_fall"}, {31'd0, tif.done}, 32'd0);
    check({name, "_idle"},      {31'd0, tif.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int dmode;
    reset = 1'b1;
    tif.start = 1'b0; tif.dividend = 32'd0; tif.divisor = 32'd0;
    @(posedge clk);
    #1;
    check("rst_result", tif.result, 32'd0);
    check("rst_busy",   {31'd0, tif.busy}, 32'd0);
    check("rst_done",   {31'd0, tif.done}, 32'd0);
    check("rst_dbz",    {31'd0, tif.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    directed("basic",   32'd100,        32'd7,          32'd2,          1'b0, 32);
    directed("allones", 32'hFFFFFFFF,   32'h00000010,   32'h0000000F,   1'b0, 32);
    directed("msb",     32'h80000000,   32'd3,          32'd2,          1'b0, 32);
    directed("bigdiv",  32'h12345678,   32'hFFFFFFFF,   32'h12345678,   1'b0, 32);
    directed("small",   32'd5,          32'd9,          32'd5,          1'b0, 32);
    directed("zeroa",   32'd0,          32'd9,          32'd0,          1'b0, 32);
    directed("divzero", 32'hDEADBEEF,   32'd0,          32'hDEADBEEF,   1'b1, 0);
    directed("clrdbz",  32'd10,         32'd3,          32'd1,          1'b0, 32);

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    tif.start = 1'b1; tif.dividend = 32'd100; tif.divisor = 32'd7;
    @(posedge clk);
    #1;
    tif.start = 1'b0;
    lat = 0;
    while (!tif.done && lat < 40) begin
      if (lat == 10) begin
        tif.start = 1'b1; tif.dividend = 32'd50; tif.divisor = 32'd6;
      end else begin
        tif.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_lat", lat, 32);
    check("ign_result", tif.result, 32'd2);
    tif.start = 1'b1; tif.dividend = 32'd50; tif.divisor = 32'd6;
    @(posedge clk);
    #1;
    tif.start = 1'b0;
    check("ign_done_once", {31'd0, tif.done}, 32'd0);
    check("ign_idle", {31'd0, tif.busy}, 32'd0);
    check("ign_hold", tif.result, 32'd2);
    directed("after_ign", 32'd100, 32'd7, 32'd2, 1'b0, 32);

    // asynchronous reset in the middle of RUN
    directed("pre_rst", 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b1, 0);
    @(negedge clk);
    tif.start = 1'b1; tif.dividend = 32'd100000; tif.divisor = 32'd7;
    @(posedge clk);
    #1;
    tif.start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_result", tif.result, 32'd0);
    check("arst_busy",   {31'd0, tif.busy}, 32'd0);
    check("arst_done",   {31'd0, tif.done}, 32'd0);
    check("arst_dbz",    {31'd0, tif.div_by_zero}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    directed("post_rst", 32'd9, 32'd4, 32'd1, 1'b0, 32);

    // randomized phase: frequent start pulses, model handles acceptance
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      tif.start = ($urandom_range(0, 99) < 20);
      tif.dividend = $urandom;
      dmode = $urandom_range(0, 99);
      if (dmode == 0)       tif.divisor = 32'd0;
      else if (dmode < 30)  tif.divisor = $urandom_range(1, 255);
      else if (dmode < 35)  tif.divisor = 32'h80000000 | $urandom;
      else                  tif.divisor = $urandom;
    end
    @(negedge clk);
    tif.start = 1'b0;
    repeat (40) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
